// File: rtl/memory_access_controller_pkg.sv
// -----------------------------------------------------------------------------
// mem_ctrl_pkg
//
// Shared definitions for the memory access controller slice:
//   - sequencer state encoding (3 bits, IDLE=0 .. FAULT=4)
//   - operation encoding held in the op register (read = 1, write = 0)
//   - MDR 2:1 source select encoding (memory read data = 1, bus = 0)
//   - a small helper that decodes "busy" from the state
// -----------------------------------------------------------------------------
package mem_ctrl_pkg;

    // State encoding. The numeric values are fixed so that the state is
    // readable on a probe.
    localparam logic [2:0] ST_IDLE   = 3'd0;
    localparam logic [2:0] ST_SETUP  = 3'd1;
    localparam logic [2:0] ST_ACCESS = 3'd2;
    localparam logic [2:0] ST_FINISH = 3'd3;
    localparam logic [2:0] ST_FAULT  = 3'd4;

    typedef enum logic [2:0] {
        IDLE   = ST_IDLE,
        SETUP  = ST_SETUP,
        ACCESS = ST_ACCESS,
        FINISH = ST_FINISH,
        FAULT  = ST_FAULT
    } state_t;

    // Operation held for the duration of one access.
    localparam logic OP_RD = 1'b1;
    localparam logic OP_WR = 1'b0;

    // MDR source select: memory read data (D1) or CPU bus (D2).
    localparam logic MDR_SEL_MEM = 1'b1;
    localparam logic MDR_SEL_BUS = 1'b0;

    // Every state except IDLE counts as busy.
    function automatic logic state_is_busy(input state_t s);
        return (s != IDLE);
    endfunction

endpackage : mem_ctrl_pkg

// File: rtl/memory_access_controller_if.sv
// -----------------------------------------------------------------------------
// memory_access_controller_if
//
// Bundles the control-unit request lines, the memory ready handshake and the
// datapath strobes produced by the memory access controller.
//
// Signals:
//   req_rd, req_wr : read / write request from the control unit (level)
//   mem_ready      : memory has completed the current access
//   mar_en         : load MAR from the bus
//   mdr_en         : MDR load enable
//   mdr_sel        : MDR source select (1 = memory data, 0 = bus)
//   mem_rd, mem_wr : memory read / write strobes
//   busy           : controller is not in IDLE
//   done           : one-cycle completion pulse
//   err            : one-cycle timeout pulse (coincident with done)
//
// Modports:
//   master : the controller side (drives strobes and status)
//   slave  : the control unit / datapath / memory side
// -----------------------------------------------------------------------------
interface memory_access_controller_if;

    logic req_rd;
    logic req_wr;
    logic mem_ready;
    logic mar_en;
    logic mdr_en;
    logic mdr_sel;
    logic mem_rd;
    logic mem_wr;
    logic busy;
    logic done;
    logic err;

    modport master (
        input  req_rd,
        input  req_wr,
        input  mem_ready,
        output mar_en,
        output mdr_en,
        output mdr_sel,
        output mem_rd,
        output mem_wr,
        output busy,
        output done,
        output err
    );

    modport slave (
        output req_rd,
        output req_wr,
        output mem_ready,
        input  mar_en,
        input  mdr_en,
        input  mdr_sel,
        input  mem_rd,
        input  mem_wr,
        input  busy,
        input  done,
        input  err
    );

endinterface : memory_access_controller_if

// File: rtl/memory_access_controller_timer.sv
// -----------------------------------------------------------------------------
// mem_wait_timer
//
// Wait-state counter for the ACCESS phase of the memory access controller.
// The counter is cleared by start, advances on tick and saturates at its
// maximum value instead of wrapping. expired flags the last permitted wait
// cycle (count == TIMEOUT-1); with TIMEOUT = 0 it never asserts.
//
// Parameters:
//   TIMEOUT : maximum number of ACCESS cycles without mem_ready (0 = off)
//   CNT_W   : counter width, TIMEOUT must be < 2**CNT_W
//
// Ports:
//   clk     : clock, rising edge
//   clr     : synchronous active-low reset (counter to 0)
//   start   : clear the counter for a new access
//   tick    : count one wait cycle
//   expired : current cycle is the last one allowed before a timeout
// -----------------------------------------------------------------------------
module mem_wait_timer #(
    parameter int TIMEOUT = 15,
    parameter int CNT_W   = 4
) (
    input  logic clk,
    input  logic clr,
    input  logic start,
    input  logic tick,
    output logic expired
);

    localparam logic [CNT_W-1:0] CNT_MAX  = '1;
    // Only meaningful when TIMEOUT != 0; the guard avoids a negative cast.
    localparam logic [CNT_W-1:0] CNT_LAST = (TIMEOUT == 0) ? '0 : CNT_W'(TIMEOUT - 1);

    logic [CNT_W-1:0] cnt_reg;
    logic [CNT_W-1:0] cnt_next;

    always_comb begin
        cnt_next = cnt_reg;
        if (start) begin
            cnt_next = '0;
        end else if (tick && (cnt_reg != CNT_MAX)) begin
            cnt_next = cnt_reg + CNT_W'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (!clr) begin
            cnt_reg <= '0;
        end else begin
            cnt_reg <= cnt_next;
        end
    end

    generate
        if (TIMEOUT == 0) begin : g_no_timeout
            assign expired = 1'b0;
        end else begin : g_timeout
            assign expired = (cnt_reg == CNT_LAST);
        end
    endgenerate

endmodule : mem_wait_timer

// File: rtl/memory_access_controller.sv
// -----------------------------------------------------------------------------
// memory_access_controller
//
// Sequencer for the CPU memory port. A read or write request taken in IDLE
// runs SETUP (MAR load, plus MDR load from the bus for a write), then ACCESS
// (memory strobe held until mem_ready or the wait-state timeout), then a
// one-cycle FINISH (done) or FAULT (done + err) before returning to IDLE.
// This block is the only driver of mar_en, mdr_en, mdr_sel, mem_rd, mem_wr.
//
// Parameters:
//   TIMEOUT : maximum ACCESS cycles without mem_ready, 0 disables the timeout
//   CNT_W   : wait counter width, TIMEOUT < 2**CNT_W
//
// Ports:
//   clk : clock, rising edge
//   clr : synchronous active-low reset
//   bus : memory_access_controller_if.master (requests, ready, strobes,
//         busy/done/err status)
// -----------------------------------------------------------------------------
module memory_access_controller
    import mem_ctrl_pkg::*;
#(
    parameter int TIMEOUT = 15,
    parameter int CNT_W   = 4
) (
    input  logic                              clk,
    input  logic                              clr,
    memory_access_controller_if.master        bus
);

    state_t state_reg;
    state_t state_next;
    logic   op_reg;
    logic   op_next;

    logic   mar_en;
    logic   mdr_en;
    logic   mdr_sel;
    logic   mem_rd;
    logic   mem_wr;
    logic   done;
    logic   err;

    logic   timer_start;
    logic   timer_tick;
    logic   timer_expired;

    mem_wait_timer #(
        .TIMEOUT (TIMEOUT),
        .CNT_W   (CNT_W)
    ) u_wait_timer (
        .clk     (clk),
        .clr     (clr),
        .start   (timer_start),
        .tick    (timer_tick),
        .expired (timer_expired)
    );

    // State and operation registers. Reset wins from any state, so an
    // access in flight is abandoned and the strobes drop at the next edge.
    always_ff @(posedge clk) begin
        if (!clr) begin
            state_reg <= IDLE;
            op_reg    <= OP_WR;
        end else begin
            state_reg <= state_next;
            op_reg    <= op_next;
        end
    end

    // Next-state and output decode.
    always_comb begin
        state_next  = state_reg;
        op_next     = op_reg;
        mar_en      = 1'b0;
        mdr_en      = 1'b0;
        mdr_sel     = MDR_SEL_BUS;
        mem_rd      = 1'b0;
        mem_wr      = 1'b0;
        done        = 1'b0;
        err         = 1'b0;
        timer_start = 1'b0;
        timer_tick  = 1'b0;

        unique case (state_reg)
            IDLE: begin
                // Read has priority when both requests are present.
                if (bus.req_rd) begin
                    op_next    = OP_RD;
                    state_next = SETUP;
                end else if (bus.req_wr) begin
                    op_next    = OP_WR;
                    state_next = SETUP;
                end
            end

            SETUP: begin
                mar_en      = 1'b1;
                timer_start = 1'b1;
                if (op_reg == OP_WR) begin
                    // Write data is captured from the bus ahead of the strobe.
                    mdr_en  = 1'b1;
                    mdr_sel = MDR_SEL_BUS;
                end
                state_next = ACCESS;
            end

            ACCESS: begin
                mem_rd = (op_reg == OP_RD);
                mem_wr = (op_reg == OP_WR);
                if (bus.mem_ready) begin
                    // Read data is valid only while mem_ready is high, so the
                    // MDR load is Mealy on mem_ready in the same cycle.
                    if (op_reg == OP_RD) begin
                        mdr_en  = 1'b1;
                        mdr_sel = MDR_SEL_MEM;
                    end
                    state_next = FINISH;
                end else if (timer_expired) begin
                    state_next = FAULT;
                end else begin
                    timer_tick = 1'b1;
                end
            end

            FINISH: begin
                done       = 1'b1;
                state_next = IDLE;
            end

            FAULT: begin
                done       = 1'b1;
                err        = 1'b1;
                state_next = IDLE;
            end

            default: begin
                state_next = IDLE;
            end
        endcase
    end

    assign bus.mar_en  = mar_en;
    assign bus.mdr_en  = mdr_en;
    assign bus.mdr_sel = mdr_sel;
    assign bus.mem_rd  = mem_rd;
    assign bus.mem_wr  = mem_wr;
    assign bus.busy    = state_is_busy(state_reg);
    assign bus.done    = done;
    assign bus.err     = err;

endmodule : memory_access_controller

// File: tb/tb_memory_access_controller.sv
// -----------------------------------------------------------------------------
// tb_memory_access_controller
//
// Directed bench for memory_access_controller with TIMEOUT = 15, CNT_W = 4.
// Outputs are packed as {mar_en, mdr_en, mdr_sel, mem_rd, mem_wr, busy, done,
// err}. Inputs change 2 time units after a rising edge and outputs are
// sampled 1 time unit later, i.e. well inside the cycle.
// -----------------------------------------------------------------------------
module tb_memory_access_controller;

    localparam logic [7:0] O_IDLE     = 8'b0000_0000;
    localparam logic [7:0] O_RSETUP   = 8'b1000_0100;
    localparam logic [7:0] O_RACC     = 8'b0001_0100;
    localparam logic [7:0] O_RACC_RDY = 8'b0111_0100;
    localparam logic [7:0] O_WSETUP   = 8'b1100_0100;
    localparam logic [7:0] O_WACC     = 8'b0000_1100;
    localparam logic [7:0] O_FIN      = 8'b0000_0110;
    localparam logic [7:0] O_FAULT    = 8'b0000_0111;

    logic clk;
    logic clr;
    int   checks;
    int   errors;

    memory_access_controller_if bus_if ();

    memory_access_controller #(
        .TIMEOUT (15),
        .CNT_W   (4)
    ) dut (
        .clk (clk),
        .clr (clr),
        .bus (bus_if)
    );

    logic [7:0] obs;
    assign obs = {bus_if.mar_en, bus_if.mdr_en, bus_if.mdr_sel, bus_if.mem_rd,
                  bus_if.mem_wr, bus_if.busy, bus_if.done, bus_if.err};

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic next_cycle();
        @(posedge clk);
        #2;
    endtask

    task automatic test_reset();
        clr = 1'b0;
        bus_if.req_rd = 1'b0;
        bus_if.req_wr = 1'b0;
        bus_if.mem_ready = 1'b0;
        next_cycle();
        next_cycle();
        #1;
        checks++;
        if (obs !== O_IDLE) begin
            errors++;
            $display("FAIL reset_outputs: got %b expected %b", obs, O_IDLE);
        end
        clr = 1'b1;
        next_cycle();
        #1;
        checks++;
        if (obs !== O_IDLE) begin
            errors++;
            $display("FAIL reset_release_idle: got %b expected %b", obs, O_IDLE);
        end
        $display("reset: outputs=%b", obs);
    endtask

    task automatic test_read_zero_wait();
        logic [7:0] exp_q [4];
        exp_q = '{O_RSETUP, O_RACC_RDY, O_FIN, O_IDLE};
        bus_if.mem_ready = 1'b1;
        bus_if.req_rd    = 1'b1;
        #1;
        // mem_ready outside ACCESS must not produce any strobe.
        checks++;
        if (obs !== O_IDLE) begin
            errors++;
            $display("FAIL rd0_idle_ready_ignored: got %b expected %b", obs, O_IDLE);
        end
        next_cycle();
        bus_if.req_rd = 1'b0;
        for (int i = 0; i < 4; i++) begin
            #1;
            checks++;
            if (obs !== exp_q[i]) begin
                errors++;
                $display("FAIL rd0_cycle%0d: got %b expected %b", i + 1, obs, exp_q[i]);
            end
            next_cycle();
        end
        bus_if.mem_ready = 1'b0;
        $display("read zero-wait: done by cycle 3");
    endtask

    task automatic test_write_wait();
        logic [7:0] exp_q [7];
        logic       rdy_q [7];
        exp_q = '{O_WSETUP, O_WACC, O_WACC, O_WACC, O_WACC, O_FIN, O_IDLE};
        rdy_q = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0};
        bus_if.req_wr = 1'b1;
        next_cycle();
        bus_if.req_wr = 1'b0;
        for (int i = 0; i < 7; i++) begin
            bus_if.mem_ready = rdy_q[i];
            #1;
            checks++;
            if (obs !== exp_q[i]) begin
                errors++;
                $display("FAIL wr3_cycle%0d: got %b expected %b", i + 1, obs, exp_q[i]);
            end
            next_cycle();
        end
        bus_if.mem_ready = 1'b0;
        $display("write 3 waits: done in cycle 6");
    endtask

    task automatic test_timeout();
        logic [7:0] exp_v;
        int         bad;
        bad = 0;
        bus_if.mem_ready = 1'b0;
        bus_if.req_rd    = 1'b1;
        next_cycle();
        bus_if.req_rd = 1'b0;
        // Cycle 1 SETUP, cycles 2..16 ACCESS, 17 FAULT, 18 IDLE.
        for (int c = 1; c <= 18; c++) begin
            if (c == 1)       exp_v = O_RSETUP;
            else if (c <= 16) exp_v = O_RACC;
            else if (c == 17) exp_v = O_FAULT;
            else              exp_v = O_IDLE;
            #1;
            checks++;
            if (obs !== exp_v) begin
                errors++;
                bad++;
                $display("FAIL timeout_cycle%0d: got %b expected %b", c, obs, exp_v);
            end
            next_cycle();
        end
        $display("timeout read: 15 access cycles then fault, mismatched cycles=%0d", bad);
    endtask

    task automatic test_simultaneous();
        logic [7:0] exp_q [8];
        exp_q = '{O_RSETUP, O_RACC_RDY, O_FIN, O_IDLE, O_WSETUP, O_WACC, O_FIN, O_IDLE};
        bus_if.mem_ready = 1'b1;
        bus_if.req_rd    = 1'b1;
        bus_if.req_wr    = 1'b1;
        next_cycle();
        bus_if.req_rd = 1'b0;
        for (int i = 0; i < 8; i++) begin
            if (i == 4) bus_if.req_wr = 1'b0;
            #1;
            checks++;
            if (obs !== exp_q[i]) begin
                errors++;
                $display("FAIL both_req_cycle%0d: got %b expected %b", i + 1, obs, exp_q[i]);
            end
            next_cycle();
        end
        bus_if.mem_ready = 1'b0;
        $display("simultaneous requests: read first, then held write");
    endtask

    task automatic test_reset_mid_access();
        logic [7:0] exp_q [4];
        exp_q = '{O_RSETUP, O_RACC_RDY, O_FIN, O_IDLE};
        bus_if.mem_ready = 1'b0;
        bus_if.req_rd    = 1'b1;
        next_cycle();
        bus_if.req_rd = 1'b0;
        #1;
        checks++;
        if (obs !== O_RSETUP) begin
            errors++;
            $display("FAIL rst_mid_setup: got %b expected %b", obs, O_RSETUP);
        end
        next_cycle();
        next_cycle();
        #1;
        checks++;
        if (obs !== O_RACC) begin
            errors++;
            $display("FAIL rst_mid_access2: got %b expected %b", obs, O_RACC);
        end
        clr = 1'b0;
        next_cycle();
        clr = 1'b1;
        #1;
        checks++;
        if (obs !== O_IDLE) begin
            errors++;
            $display("FAIL rst_mid_after_clr: got %b expected %b", obs, O_IDLE);
        end
        next_cycle();
        #1;
        checks++;
        if (obs !== O_IDLE) begin
            errors++;
            $display("FAIL rst_mid_no_done: got %b expected %b", obs, O_IDLE);
        end
        bus_if.req_rd    = 1'b1;
        bus_if.mem_ready = 1'b1;
        next_cycle();
        bus_if.req_rd = 1'b0;
        for (int i = 0; i < 4; i++) begin
            #1;
            checks++;
            if (obs !== exp_q[i]) begin
                errors++;
                $display("FAIL rst_mid_reread_cycle%0d: got %b expected %b", i + 1, obs, exp_q[i]);
            end
            next_cycle();
        end
        bus_if.mem_ready = 1'b0;
        $display("reset mid-access: aborted, new read completes in 3 cycles");
    endtask

    task automatic test_ignored_requests();
        logic [7:0] exp_q [7];
        logic       rdy_q [7];
        exp_q = '{O_RSETUP, O_RACC, O_RACC, O_RACC, O_RACC_RDY, O_FIN, O_IDLE};
        rdy_q = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0};
        bus_if.req_rd = 1'b1;
        next_cycle();
        bus_if.req_rd = 1'b0;
        for (int i = 0; i < 7; i++) begin
            bus_if.mem_ready = rdy_q[i];
            // Toggle req_wr during the wait cycles only.
            bus_if.req_wr = (i >= 1 && i <= 3) ? ~bus_if.req_wr : 1'b0;
            #1;
            checks++;
            if (obs !== exp_q[i]) begin
                errors++;
                $display("FAIL ignored_req_cycle%0d: got %b expected %b", i + 1, obs, exp_q[i]);
            end
            next_cycle();
        end
        bus_if.req_wr    = 1'b0;
        bus_if.mem_ready = 1'b0;
        $display("ignored requests: write toggles during read had no effect");
    endtask

    initial begin
        checks = 0;
        errors = 0;
        clr    = 1'b0;
        bus_if.req_rd    = 1'b0;
        bus_if.req_wr    = 1'b0;
        bus_if.mem_ready = 1'b0;
        test_reset();
        test_read_zero_wait();
        test_write_wait();
        test_timeout();
        test_simultaneous();
        test_reset_mid_access();
        test_ignored_requests();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL watchdog: got no finish expected finish before time limit");
        $fatal(1, "time limit exceeded");
    end

endmodule : tb_memory_access_controller

// File: doc/memory_access_controller.md
# memory_access_controller

Sequencer for the CPU memory port: on a read or write request from the control unit it drives the MAR load, the memory data register load and its 2:1 source select, and the memory read/write strobes. It also waits on a memory ready handshake with a bounded wait-state timeout. It sits between the control unit FSM and the MAR/MDR/memory datapath, and is the only block allowed to assert `mdr_en`, `mdr_sel`, `mar_en`, `mem_rd` and `mem_wr`.

## Interface
Parameters:
- `TIMEOUT`, default 15: maximum wait cycles for `mem_ready`; 0 disables the timeout.
- `CNT_W`, default 4: width of the wait counter; must satisfy `TIMEOUT < 2**CNT_W`.

Ports (name, direction, width, meaning):
- `clk` in 1: single clock, all state updates on the rising edge.
- `clr` in 1: reset, synchronous, active-low.
- `req_rd` in 1: read request, level, sampled only in IDLE.
- `req_wr` in 1: write request, level, sampled only in IDLE.
- `mem_ready` in 1: memory has completed the current access.
- `mar_en` out 1: load MAR from bus.
- `mdr_en` out 1: MDR load enable.
- `mdr_sel` out 1: MDR source select; 1 = memory read data (D1), 0 = bus (D2).
- `mem_rd` out 1: memory read strobe.
- `mem_wr` out 1: memory write strobe.
- `busy` out 1: high in every state except IDLE.
- `done` out 1: one-cycle completion pulse.
- `err` out 1: one-cycle timeout pulse, coincident with `done`.

## Operation
- States: IDLE, SETUP, ACCESS, FINISH, FAULT. An `op` register holds 1 for a read and 0 for a write.
- **IDLE:** all outputs 0.
  - `req_rd` high: set `op`=1, go to SETUP.
  - Only `req_wr` high: set `op`=0, go to SETUP.
  - Both high: read wins.
- **SETUP** (one cycle): `mar_en`=1. For a write, also `mdr_en`=1 and `mdr_sel`=0 (MDR captures bus data). Clear the wait counter. Go to ACCESS.
- **ACCESS:** `mem_rd`=`op`, `mem_wr`=!`op`.
  - `mem_ready` high on a read: `mdr_en`=1 and `mdr_sel`=1 in the same cycle (Mealy), then go to FINISH.
  - `mem_ready` high on a write: go to FINISH.
  - `mem_ready` low: increment the counter. When `TIMEOUT`≠0 and counter == `TIMEOUT`-1, go to FAULT instead.
- **FINISH:** `done`=1, then go to IDLE.
- **FAULT:** `done`=1 and `err`=1. No MDR load, strobes low. Go to IDLE.
- Requests during non-IDLE states are ignored, not queued. A request still high in IDLE after `done` starts a new access.
- `mdr_sel` is 0 whenever `mdr_en` is 0.

## Timing
- **Reset:** `clr` low at an edge forces IDLE, `op`=0 and counter=0, regardless of state, including mid-ACCESS. All outputs are 0 in the cycle after that edge; strobes drop immediately.
- **Latency:** a request seen at edge N gives SETUP in cycle N+1 and ACCESS from N+2. `mem_ready` high in the first ACCESS cycle gives `done` at N+3. Minimum request-to-`done` is 3 cycles; each wait cycle adds 1.
- **Timeout:** with `TIMEOUT`=T, ACCESS lasts exactly T cycles without `mem_ready`, then one FAULT cycle. `mem_ready` arriving in the last ACCESS cycle counts as success.
- The counter saturates and never wraps.
- `mem_ready` outside ACCESS is ignored.

## Structure
- Shared package `mem_ctrl_pkg`:
  - state encoding constants (IDLE=0, SETUP=1, ACCESS=2, FINISH=3, FAULT=4; 3 bits);
  - `OP_RD`=1 and `OP_WR`=0;
  - `MDR_SEL_MEM`=1 and `MDR_SEL_BUS`=0.
- One sub-module, `mem_wait_timer`: ports clr/start/tick, a `CNT_W` counter, and an `expired` compare against `TIMEOUT`.
- The FSM and output decode stay in the top module.

## Test plan
- **Read, zero wait:** reset, then `req_rd`=1 at edge 0 with `mem_ready` tied high.
  - `mar_en` high in cycle 1; `mem_rd`, `mdr_en` and `mdr_sel` all 1 in cycle 2; `done`=1 in cycle 3; `busy` low from cycle 4.
- **Write, 3 wait states:** `req_wr` pulse, `mem_ready` high on the 4th ACCESS cycle.
  - Cycle 1: `mar_en`=1, `mdr_en`=1, `mdr_sel`=0.
  - `mem_wr` high for exactly 4 cycles, with no MDR load during ACCESS.
  - `done` in cycle 6.
- **Timeout:** `TIMEOUT`=15, read request, `mem_ready` held low.
  - `mem_rd` high for 15 cycles, then `done`=`err`=1 for one cycle.
  - `mdr_en` never high after SETUP.
- **Simultaneous requests:** `req_rd`=`req_wr`=1 in IDLE → read sequence. Then drop `req_rd`, keep `req_wr` → write sequence starts in the cycle after `done`.
- **Reset mid-access:** `clr`=0 during the 2nd ACCESS cycle of a read → all outputs 0 the next cycle, no `done`. After release, a new read completes in 3 cycles with the counter restarted at 0.
- **Ignored requests:** toggle `req_wr` while a read is in ACCESS → no `mem_wr`, and the read completes normally.
